// File: rtl/registrador_pkg.sv
// Shared constants for the shift-register controller: register mode encodings,
// operation encodings and the controller state type.
package registrador_pkg;

    // {ch1,ch0} values understood by the downstream 16-bit register
    localparam logic [1:0] HOLD   = 2'b00;
    localparam logic [1:0] LOAD   = 2'b01;
    localparam logic [1:0] SHIFT  = 2'b10;
    localparam logic [1:0] ROTATE = 2'b11;

    // modo_op encodings; 2'b11 behaves like MODO_CARGA
    localparam logic [1:0] MODO_CARGA     = 2'b00;
    localparam logic [1:0] MODO_DESLOCA   = 2'b01;
    localparam logic [1:0] MODO_ROTACIONA = 2'b10;

    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        CARREGA = 2'b01,
        DESLOCA = 2'b10,
        FIM     = 2'b11
    } estado_t;

endpackage

// File: rtl/controle_deslocamento_if.sv
// Request and register-control signals of the shift-register controller.
// The slave modport is the controller; the master modport is its requester/register side.
interface controle_deslocamento_if;

    logic        start;
    logic [15:0] dado;
    logic [1:0]  modo_op;
    logic [3:0]  qtd;
    logic        serial_in;
    logic        ch0;
    logic        ch1;
    logic        d;
    logic [15:0] bits;
    logic        ocupado;
    logic        pronto;

    modport slave (
        input  start, dado, modo_op, qtd, serial_in,
        output ch0, ch1, d, bits, ocupado, pronto
    );

    modport master (
        output start, dado, modo_op, qtd, serial_in,
        input  ch0, ch1, d, bits, ocupado, pronto
    );

endinterface

// File: rtl/controle_deslocamento.sv
// Moore FSM that sequences a 16-bit shift register: one parallel load, then
// qtd shift/rotate cycles, then a one-cycle completion pulse.
module controle_deslocamento
    import registrador_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    controle_deslocamento_if.slave    bus
);

    estado_t     state_q, state_d;
    logic [15:0] dado_q, dado_d;
    logic [1:0]  modo_q, modo_d;
    logic [3:0]  qtd_q, qtd_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        modo_movimenta;
    logic [1:0]  ch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= OCIOSO;
            dado_q  <= '0;
            modo_q  <= '0;
            qtd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dado_q  <= dado_d;
            modo_q  <= modo_d;
            qtd_q   <= qtd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign modo_movimenta = (modo_q == MODO_DESLOCA) || (modo_q == MODO_ROTACIONA);

    always_comb begin
        state_d = state_q;
        dado_d  = dado_q;
        modo_d  = modo_q;
        qtd_d   = qtd_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            OCIOSO: begin
                if (bus.start) begin
                    dado_d  = bus.dado;
                    modo_d  = bus.modo_op;
                    qtd_d   = bus.qtd;
                    state_d = CARREGA;
                end
            end
            CARREGA: begin
                if (modo_movimenta && (qtd_q != 4'd0)) begin
                    cnt_d   = qtd_q;
                    state_d = DESLOCA;
                end else begin
                    state_d = FIM;
                end
            end
            DESLOCA: begin
                // Leaving on the cycle the counter reads 1 gives exactly qtd cycles here
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = FIM;
                end
            end
            FIM: begin
                state_d = OCIOSO;
            end
            default: begin
                state_d = OCIOSO;
            end
        endcase
    end

    always_comb begin
        ch          = HOLD;
        bus.d       = 1'b0;
        bus.bits    = '0;
        bus.ocupado = 1'b0;
        bus.pronto  = 1'b0;
        unique case (state_q)
            CARREGA: begin
                ch          = LOAD;
                bus.bits    = dado_q;
                bus.ocupado = 1'b1;
            end
            DESLOCA: begin
                bus.ocupado = 1'b1;
                if (modo_q == MODO_DESLOCA) begin
                    ch    = SHIFT;
                    bus.d = bus.serial_in;
                end else begin
                    ch = ROTATE;
                end
            end
            FIM: begin
                bus.pronto = 1'b1;
            end
            default: begin
                ch = HOLD;
            end
        endcase
    end

    assign bus.ch0 = ch[0];
    assign bus.ch1 = ch[1];

endmodule

// File: tb/tb_controle_deslocamento.sv
// Directed bench for controle_deslocamento driving a behavioural 16-bit register.
module tb_controle_deslocamento;
    import registrador_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] reg_q;
    int          checks;
    int          failures;
    logic        saw_bad;

    controle_deslocamento_if bus();

    controle_deslocamento dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream register controlled by {ch1,ch0}
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_q <= '0;
        end else begin
            case ({bus.ch1, bus.ch0})
                LOAD:    reg_q <= bus.bits;
                SHIFT:   reg_q <= {reg_q[14:0], bus.d};
                ROTATE:  reg_q <= {reg_q[14:0], reg_q[15]};
                default: reg_q <= reg_q;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] v_dado, input logic [1:0] v_modo,
                                 input logic [3:0] v_qtd);
        bus.dado    = v_dado;
        bus.modo_op = v_modo;
        bus.qtd     = v_qtd;
        bus.start   = 1'b1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
            $error("[TB] check %s", tag);
        end
    endtask

    function automatic logic [31:0] outs();
        return {11'd0, bus.ch1, bus.ch0, bus.d, bus.ocupado, bus.pronto, bus.bits};
    endfunction

    // Packs expected {ch, d, ocupado, pronto, bits} in the same layout as outs()
    function automatic logic [31:0] exp_outs(input logic [1:0] ch, input logic dv,
                                             input logic oc, input logic pr,
                                             input logic [15:0] bv);
        return {11'd0, ch, dv, oc, pr, bv};
    endfunction

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.dado    = '0;
        bus.modo_op = '0;
        bus.qtd     = '0;
        bus.serial_in = 1'b0;
        #1;
        checkOutput("reset_outputs", outs(), exp_outs(HOLD, 0, 0, 0, 16'h0000));
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("idle_outputs", outs(), exp_outs(HOLD, 0, 0, 0, 16'h0000));

        // Load-only: one LOAD cycle, pronto at N+2
        applyStimulus(16'hA5C3, MODO_CARGA, 4'd7);
        tick();
        bus.start = 1'b0;
        checkOutput("load_carrega", outs(), exp_outs(LOAD, 0, 1, 0, 16'hA5C3));
        tick();
        checkOutput("load_fim", outs(), exp_outs(HOLD, 0, 0, 1, 16'h0000));
        checkOutput("load_register", {16'd0, reg_q}, 32'h0000_A5C3);
        tick();
        checkOutput("load_back_idle", outs(), exp_outs(HOLD, 0, 0, 0, 16'h0000));

        // Shift four times with serial fill of 1
        bus.serial_in = 1'b1;
        applyStimulus(16'h0001, MODO_DESLOCA, 4'd4);
        tick();
        bus.start = 1'b0;
        checkOutput("shift_carrega", outs(), exp_outs(LOAD, 0, 1, 0, 16'h0001));
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("shift_desloca%0d", i), outs(),
                        exp_outs(SHIFT, 1, 1, 0, 16'h0000));
        end
        tick();
        checkOutput("shift_fim", outs(), exp_outs(HOLD, 0, 0, 1, 16'h0000));
        checkOutput("shift_register", {16'd0, reg_q}, 32'h0000_001F);
        bus.serial_in = 1'b0;
        tick();

        // Rotate once: 8001 -> 0003
        applyStimulus(16'h8001, MODO_ROTACIONA, 4'd1);
        tick();
        bus.start = 1'b0;
        checkOutput("rot_carrega", outs(), exp_outs(LOAD, 0, 1, 0, 16'h8001));
        tick();
        checkOutput("rot_desloca", outs(), exp_outs(ROTATE, 0, 1, 0, 16'h0000));
        tick();
        checkOutput("rot_fim", outs(), exp_outs(HOLD, 0, 0, 1, 16'h0000));
        checkOutput("rot_register", {16'd0, reg_q}, 32'h0000_0003);
        tick();

        // Shift mode with qtd=0 goes straight to FIM
        applyStimulus(16'h1234, MODO_DESLOCA, 4'd0);
        tick();
        bus.start = 1'b0;
        checkOutput("q0_carrega", outs(), exp_outs(LOAD, 0, 1, 0, 16'h1234));
        tick();
        checkOutput("q0_fim", outs(), exp_outs(HOLD, 0, 0, 1, 16'h0000));
        tick();

        // Reset during the third DESLOCA cycle of a 10-cycle shift
        bus.serial_in = 1'b1;
        applyStimulus(16'h00F0, MODO_DESLOCA, 4'd10);
        tick();
        bus.start = 1'b0;
        tick();
        checkOutput("rst_desloca1", outs(), exp_outs(SHIFT, 1, 1, 0, 16'h0000));
        bus.serial_in = 1'b0;
        #1;
        checkOutput("d_follows_serial", {31'd0, bus.d}, 32'd0);
        bus.serial_in = 1'b1;
        tick();
        tick();
        checkOutput("rst_desloca3", outs(), exp_outs(SHIFT, 1, 1, 0, 16'h0000));
        rst = 1'b1;
        #1;
        checkOutput("rst_abort_outputs", outs(), exp_outs(HOLD, 0, 0, 0, 16'h0000));
        tick();
        rst = 1'b0;
        saw_bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.pronto || bus.ocupado) saw_bad = 1'b1;
        end
        checkOutput("rst_stays_idle", {31'd0, saw_bad}, 32'd0);

        // start held high; dado changes mid-run
        bus.serial_in = 1'b0;
        applyStimulus(16'h1111, MODO_CARGA, 4'd0);
        tick();
        bus.dado = 16'h2222;
        checkOutput("held_carrega1", outs(), exp_outs(LOAD, 0, 1, 0, 16'h1111));
        tick();
        checkOutput("held_fim1", outs(), exp_outs(HOLD, 0, 0, 1, 16'h0000));
        checkOutput("held_register1", {16'd0, reg_q}, 32'h0000_1111);
        tick();
        checkOutput("held_idle_gap", outs(), exp_outs(HOLD, 0, 0, 0, 16'h0000));
        tick();
        bus.dado = 16'h3333;
        checkOutput("held_carrega2", outs(), exp_outs(LOAD, 0, 1, 0, 16'h2222));
        tick();
        bus.start = 1'b0;
        checkOutput("held_fim2", outs(), exp_outs(HOLD, 0, 0, 1, 16'h0000));
        checkOutput("held_register2", {16'd0, reg_q}, 32'h0000_2222);
        tick();
        tick();
        checkOutput("held_final_idle", outs(), exp_outs(HOLD, 0, 0, 0, 16'h0000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
